// File: rtl/cic_pkg.sv
// Shared DSP helpers for the CIC filters: log2 of a power of two and the
// register-width / gain-normalising shift derivations.
package cic_pkg;

    function automatic int cic_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Register growth of N stages at total rate change R*M.
    function automatic int cic_width(input int dw, input int n, input int r, input int m);
        return dw + n * cic_log2(r * m);
    endfunction

    // Interpolator DC gain is (R*M)^N / R, so this shift restores unity gain.
    function automatic int cic_shift(input int n, input int r, input int m);
        return n * cic_log2(r * m) - cic_log2(r);
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: registers din minus din delayed by M enabled updates.
module cic_comb #(
    parameter int WI = 25,
    parameter int M  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [WI-1:0] din,
    output logic [WI-1:0] dout
);
    logic [WI-1:0] dly [M];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            for (int i = 0; i < M; i++) dly[i] <= '0;
        end else if (en) begin
            dout   <= din - dly[M-1];
            dly[0] <= din;
            for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
        end
    end

endmodule

// File: rtl/cic_integrator.sv
// One CIC integrator stage: wrap-around accumulator updated when en is high.
module cic_integrator #(
    parameter int WI = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [WI-1:0] din,
    output logic [WI-1:0] dout
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (en) begin
            dout <= dout + din;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: N combs at the input rate, zero-stuffing by R, N integrators
// at the output rate, then a fixed shift for unity DC gain.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int DW = 16,
    parameter int N  = 3,
    parameter int R  = 8,
    parameter int M  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic signed [DW-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);
    localparam int WI    = cic_width(DW, N, R, M);
    localparam int SHIFT = cic_shift(N, R, M);
    localparam int PW    = cic_log2(R);

    logic [PW-1:0] phase;
    logic          out_free;
    logic          adv;
    logic          accept;

    // Handshake: a beat transfers on a rising edge where ce, valid and ready are
    // all high; valid never depends on ready, and data holds until it transfers.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = ce && (phase == '0) && out_free;
    assign adv      = ce && out_free && ((phase != '0) || s_valid);
    assign accept   = s_valid && s_ready;

    logic        [WI-1:0] comb_in  [N];
    logic        [WI-1:0] comb_out [N];
    logic        [WI-1:0] int_in   [N];
    logic        [WI-1:0] int_out  [N];
    logic signed [WI-1:0] int_last;

    assign int_last = int_out[N-1];

    for (genvar g = 0; g < N; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign comb_in[g] = {{(WI-DW){s_data[DW-1]}}, s_data};
            // Zero-stuffing: the comb result enters only on the phase-0 step.
            assign int_in[g]  = (phase == '0) ? comb_out[N-1] : '0;
        end else begin : g_link
            assign comb_in[g] = comb_out[g-1];
            assign int_in[g]  = int_out[g-1];
        end

        cic_comb #(
            .WI(WI),
            .M (M)
        ) u_comb (
            .clk  (clk),
            .reset(reset),
            .en   (accept),
            .din  (comb_in[g]),
            .dout (comb_out[g])
        );

        cic_integrator #(
            .WI(WI)
        ) u_integrator (
            .clk  (clk),
            .reset(reset),
            .en   (adv),
            .din  (int_in[g]),
            .dout (int_out[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (adv) begin
            phase   <= (phase == PW'(R - 1)) ? '0 : phase + 1'b1;
            m_data  <= DW'(int_last >>> SHIFT);
            m_valid <= 1'b1;
        end else if (ce && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: scoreboard against a sequence-level CIC model,
// plus directed DC, impulse, rate, backpressure, ce and reset scenarios.
module tb_cic_interpolator;
    localparam int DW    = 16;
    localparam int N     = 3;
    localparam int R     = 8;
    localparam int M     = 1;
    localparam int BITS  = N * $clog2(R * M);
    localparam int WI    = DW + BITS;
    localparam int SHIFT = BITS - $clog2(R);
    localparam int D     = N * R + N;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 ce, m_ready;
    logic signed [DW-1:0] s_data, m_data;
    logic                 s_valid, s_ready, m_valid;
    logic signed [DW-1:0] s_data2, m_data2;
    logic                 s_valid2, s_ready2, m_valid2;

    cic_interpolator #(.DW(DW), .N(N), .R(R), .M(M)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    cic_interpolator #(.DW(DW), .N(1), .R(4), .M(1)) dut_imp (
        .clk(clk), .reset(reset), .ce(ce),
        .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // reference model: y = SumN( upsample_R( DiffN_M(x) ) ), delayed D, scaled
    logic [DW-1:0]        exp_q[$];
    logic signed [DW-1:0] out_log[$];
    logic signed [DW-1:0] dc_trace[$];
    logic signed [DW-1:0] out2[$];
    longint xh[$];
    longint hist[$];
    longint sacc[N];

    function automatic longint binom(input int n, input int k);
        longint b = 1;
        for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
        return b;
    endfunction

    function automatic logic [DW-1:0] quantise(input longint y);
        logic signed [WI-1:0] w;
        w = WI'(y);
        w = w >>> SHIFT;
        return w[DW-1:0];
    endfunction

    task automatic model_clear();
        xh.delete();
        hist.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) sacc[i] = 0;
    endtask

    task automatic model_accept(input logic signed [DW-1:0] x);
        longint d, v;
        int j, k;
        xh.push_back(longint'(x));
        j = xh.size() - 1;
        d = 0;
        for (int i = 0; i <= N; i++)
            if (j - i * M >= 0)
                d += ((i % 2) ? -1 : 1) * binom(N, i) * xh[j - i * M];
        for (int r = 0; r < R; r++) begin
            v = (r == 0) ? d : 0;
            sacc[0] += v;
            for (int s = 1; s < N; s++) sacc[s] += sacc[s-1];
            hist.push_back(sacc[N-1]);
        end
        for (int r = 0; r < R; r++) begin
            k = j * R + r;
            exp_q.push_back((k < D) ? quantise(0) : quantise(hist[k - D]));
        end
    endtask

    // scoreboard monitor: records accepted inputs, compares every output beat
    always @(negedge clk) begin
        if (reset) begin
            model_clear();
        end else begin
            if (ce && m_valid && m_ready) begin
                out_log.push_back(m_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got output %0d, expected none", m_data);
                end else begin
                    check("scoreboard", longint'(m_data), longint'($signed(exp_q.pop_front())));
                end
            end
            if (s_valid && s_ready) model_accept(s_data);
        end
        if (!reset && ce && m_valid2 && m_ready && out2.size() < 12) out2.push_back(m_data2);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int cnt_sr, cnt_hs, found;
    logic signed [DW-1:0] held;
    logic held_v;
    int exp_imp[12];

    initial begin
        exp_imp = '{0, 0, 0, 0, 0, 100, 100, 100, 100, 0, 0, 0};
        reset = 1'b1; ce = 1'b1; m_ready = 1'b1;
        s_data = '0; s_valid = 1'b0; s_data2 = '0; s_valid2 = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_data", m_data, 0);
        cycle();
        reset = 1'b0;
        @(negedge clk);
        check("idle_s_ready", s_ready, 1);
        cycle();

        // impulse on N=1, R=4
        s_data2 = 16'sd100; s_valid2 = 1'b1; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (s_ready2) found = 1;
            cycle();
        end
        check("impulse_accept", found, 1);
        s_data2 = '0;
        for (int i = 0; i < 100 && out2.size() < 12; i++) cycle();
        s_valid2 = 1'b0;
        check("impulse_count", out2.size(), 12);
        for (int i = 0; i < out2.size(); i++) check("impulse_seq", out2[i], exp_imp[i]);

        // DC step
        out_log.delete();
        s_data = 16'sd1000; s_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cycle();
        end
        check("dc_log_len", out_log.size() >= 56, 1);
        for (int i = 48; i < 56 && i < out_log.size(); i++) check("dc_step", out_log[i], 1000);
        dc_trace = out_log;

        // rate: one accept per R output beats
        cnt_sr = 0; cnt_hs = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_ready) cnt_sr++;
            if (ce && m_valid && m_ready) cnt_hs++;
            cycle();
        end
        check("rate_s_ready", cnt_sr, 64 / R);
        check("rate_beats", cnt_hs, 64);

        // backpressure mid-burst
        for (int i = 0; i < 12; i++) begin
            s_data = DW'($urandom_range(0, 65535));
            cycle();
        end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) held = m_data;
            else check("stall_m_data", m_data, held);
            check("stall_m_valid", m_valid, 1);
            check("stall_s_ready", s_ready, 0);
            cycle();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = DW'($urandom_range(0, 65535));
            cycle();
        end

        // clock-enable gating
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                held = m_data;
                held_v = m_valid;
            end else begin
                check("ce_m_data", m_data, held);
                check("ce_m_valid", m_valid, held_v);
            end
            check("ce_s_ready", s_ready, 0);
            cycle();
        end
        ce = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // reset at phase 5, then replay the DC step
        s_data = 16'sd1000; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (s_valid && s_ready) found = 1;
            else cycle();
        end
        check("phase0_found", found, 1);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset_m_valid", m_valid, 0);
        check("midreset_m_data", m_data, 0);
        @(negedge clk);
        out_log.delete();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cycle();
        end
        check("replay_len", out_log.size() >= 56, 1);
        for (int i = 0; i < 56 && i < out_log.size() && i < dc_trace.size(); i++)
            check("replay_trace", out_log[i], dc_trace[i]);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            ce      = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 7);
            s_data  = DW'($urandom_range(0, 65535));
            cycle();
        end

        // drain
        ce = 1'b1; m_ready = 1'b1; s_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
